lcd_cmd_issuer: RTL and testbench

- Upstream stage of the LCD image controller. Accepts 4-bit image commands from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the controller as a single-cycle cmd/cmd_valid pulse, only while the controller's busy is low.
- Stops issuing after a WRITE command until the controller's done arrives, then reports completion.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/cmd_fifo.sv | 35 +++
 rtl/lcd_cmd_issuer.sv | 104 ++++++++++
 tb/tb_lcd_cmd_issuer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes and issuer state encoding shared by the LCD image controller blocks
package lcd_pkg;
  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_MAX      = 4'd5;
  localparam logic [3:0] CMD_MIN      = 4'd6;
  localparam logic [3:0] CMD_AVG      = 4'd7;
  localparam logic [3:0] CMD_CCW      = 4'd8;
  localparam logic [3:0] CMD_CW       = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
  localparam logic [3:0] CMD_LAST     = CMD_MIRROR_Y;
  typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, WAIT_DONE, FIN} state_e;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous 4-bit FIFO with occupancy level and asynchronous reset
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [3:0]               din,
  output logic [3:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign full  = lvl_q == (AW+1)'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
endmodule

// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer: buffers host commands and issues them one at a time to the LCD controller
module lcd_cmd_issuer
  import lcd_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             host_cmd,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [3:0]             lcd_cmd,
  output logic                   lcd_cmd_valid,
  input  logic                   lcd_busy,
  input  logic                   lcd_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       cmd_count,
  output logic                   err_illegal,
  output logic                   finished
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             fin_q, fin_d;
  logic             full, empty, pop, accept;
  logic [3:0]       head;
  assign host_ready = !full && !fin_q;
  assign accept     = host_valid && host_ready;
  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && host_cmd <= CMD_LAST),
    .pop   (pop),
    .din   (host_cmd),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cmd_d   = cmd_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    err_d   = err_q || (accept && host_cmd > CMD_LAST);
    pop     = 1'b0;
    case (state_q)
      IDLE:
        if (!empty && !lcd_busy) begin
          pop     = 1'b1;
          cmd_d   = head;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = ISSUE;
        end
      ISSUE: begin
        hold_d  = HW'(HOLD_CYC - 1);
        state_d = HOLD;
      end
      HOLD:
        if (hold_q == '0) state_d = (cmd_q == CMD_WRITE) ? WAIT_DONE : WAIT;
        else hold_d = hold_q - 1'b1;
      WAIT:
        if (!lcd_busy) state_d = IDLE;
      WAIT_DONE:
        if (lcd_done) begin
          fin_d   = 1'b1;
          state_d = FIN;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
    end
  assign lcd_cmd       = cmd_q;
  assign lcd_cmd_valid = valid_q;
  assign cmd_count     = cnt_q;
  assign err_illegal   = err_q;
  assign finished      = fin_q;
endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// tb_lcd_cmd_issuer: directed and random stimulus checked against a queue-based reference model
module tb_lcd_cmd_issuer;
  localparam int DEPTH = 4, HOLD_CYC = 2, CNT_W = 8;
  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       host_cmd;
  logic             host_valid, host_ready;
  logic [3:0]       lcd_cmd;
  logic             lcd_cmd_valid, lcd_busy, lcd_done;
  logic [2:0]       fifo_level;
  logic [CNT_W-1:0] cmd_count;
  logic             err_illegal, finished;
  always #5 clk = ~clk;
  lcd_cmd_issuer #(.DEPTH(DEPTH), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .fifo_level    (fifo_level),
    .cmd_count     (cmd_count),
    .err_illegal   (err_illegal),
    .finished      (finished)
  );
  int n_chk = 0, n_err = 0;
  int q[$];
  int m_cmd, m_valid, m_cnt, m_err, m_fin, cool, need_low, need_done;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    q.delete();
    m_cmd = 0; m_valid = 0; m_cnt = 0; m_err = 0; m_fin = 0;
    cool = 0; need_low = 0; need_done = 0;
  endtask
  task automatic check_all();
    check("lcd_cmd_valid", 32'(lcd_cmd_valid), 32'(m_valid));
    check("lcd_cmd", 32'(lcd_cmd), 32'(m_cmd));
    check("cmd_count", 32'(cmd_count), 32'(m_cnt));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("err_illegal", 32'(err_illegal), 32'(m_err));
    check("finished", 32'(finished), 32'(m_fin));
    check("host_ready", 32'(host_ready), 32'(q.size() < DEPTH && m_fin == 0));
  endtask
  task automatic step(input bit v, input int c, input bit b, input bit d);
    bit acc;
    host_valid = v;
    host_cmd   = 4'(c);
    lcd_busy   = b;
    lcd_done   = d;
    @(posedge clk);
    acc = v && q.size() < DEPTH && m_fin == 0;
    m_valid = 0;
    if (m_fin == 0 && cool == 0 && need_low == 0 && need_done == 0) begin
      if (q.size() > 0 && !b) begin
        m_cmd   = q.pop_front();
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        cool    = 1 + HOLD_CYC;
        if (m_cmd == 0) need_done = 1;
        else need_low = 1;
      end
    end else if (cool > 0) cool--;
    else if (need_low != 0) begin
      if (!b) need_low = 0;
    end else if (need_done != 0) begin
      if (d) begin
        need_done = 0;
        m_fin     = 1;
      end
    end
    if (acc) begin
      if (c > 11) m_err = 1;
      else q.push_back(c);
    end
    #1 check_all();
  endtask
  task automatic do_reset();
    reset      = 1'b1;
    host_valid = 1'b0;
    @(posedge clk);
    #1 m_reset();
    check_all();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b0; host_valid = 1'b0; host_cmd = '0; lcd_busy = 1'b0; lcd_done = 1'b0;
    do_reset();
    step(1, 3, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(1, 5, 0, 0);
    step(1, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    repeat (8) step(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0);
    step(1, 5, 1, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 0);
    step(1, 13, 0, 0);
    step(1, 9, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      repeat (250) step($urandom_range(0, 1) == 1,
                        ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15)),
                        $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      do_reset();
    end
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 8, 0, 1);
    repeat (10) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0);
    step(1, 7, 0, 0);
    do_reset();
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    host_valid = 1'b0;
    reset = 1'b1;
    #1 m_reset();
    check_all();
    #1 reset = 1'b0;
    repeat (8) step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
